alarm_bank: RTL

Multi-channel alarm controller for the clock.
- Holds N_ALARMS programmable alarm times (BCD HH:MM) with per-channel enable.
- Compares them against the running time and sequences a single shared ringer through ringing, snooze and timeout.
- Sits beside the time counter; consumes its BCD digits and its second/minute tick pulses; drives the buzzer/LED.

---
 rtl/alarm_bank.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alarm_bank.sv
// Multi-channel BCD alarm controller: stores N_ALARMS HH:MM slots, detects
// rising matches against the running time and drives one shared ringer.
//
// state   | meaning
// IDLE    | no ring in progress; serves lowest pending slot
// RINGING | alarm/beep active for alarm_id until ack, snooze or timeout
// SNOOZE  | silent countdown in minutes before re-ringing alarm_id
module alarm_bank #(
  parameter int N_ALARMS    = 4,
  parameter int ID_W        = 2,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 5,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sec_tick,
  input  logic            min_tick,
  input  logic [3:0]      uminuto,
  input  logic [3:0]      dminuto,
  input  logic [3:0]      uhoras,
  input  logic [3:0]      dhoras,
  input  logic            wr_en,
  input  logic [ID_W-1:0] wr_idx,
  input  logic [15:0]     wr_time,
  input  logic            wr_enable,
  input  logic [ID_W-1:0] rd_idx,
  output logic [15:0]     rd_time,
  output logic            rd_enable,
  input  logic            ack,
  input  logic            snooze,
  output logic            alarm,
  output logic            beep,
  output logic [ID_W-1:0] alarm_id,
  output logic            snoozing,
  output logic            missed
);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  localparam logic [7:0] RING_LD   = 8'(RING_SECS);
  localparam logic [3:0] SNOOZE_LD = 4'(SNOOZE_MINS);
  localparam logic [3:0] SNZ_MAX   = 4'(MAX_SNOOZE);

  state_t                state, state_nxt;
  logic [15:0]           slot_time [N_ALARMS];
  logic [N_ALARMS-1:0]   slot_en;
  logic [N_ALARMS-1:0]   pending, pending_nxt;
  logic [N_ALARMS-1:0]   prev_match, match, trigger;
  logic [ID_W-1:0]       id_r, id_nxt, sel_idx;
  logic                  sel_vld;
  logic [7:0]            ring_cnt, ring_nxt;
  logic [3:0]            snz_cnt, snz_nxt;
  logic [3:0]            min_cnt, min_nxt;
  logic                  beep_r, beep_nxt;
  logic                  missed_r, missed_nxt;
  logic                  abort;
  logic [15:0]           cur_time;

  assign cur_time = {dhoras, uhoras, dminuto, uminuto};

  always_comb begin
    match = '0;
    for (int i = 0; i < N_ALARMS; i++)
      match[i] = slot_en[i] && (slot_time[i] == cur_time);
  end

  assign trigger = match & ~prev_match;

  always_comb begin
    sel_idx = '0;
    sel_vld = 1'b0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx = ID_W'(i);
        sel_vld = 1'b1;
      end
    end
  end

  // Disabling the slot currently being serviced cancels the ring silently.
  assign abort = wr_en && !wr_enable && (wr_idx == id_r) && (state != IDLE);

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending | trigger;
    id_nxt      = id_r;
    ring_nxt    = ring_cnt;
    snz_nxt     = snz_cnt;
    min_nxt     = min_cnt;
    beep_nxt    = beep_r;
    missed_nxt  = missed_r;
    if (ack)
      missed_nxt = 1'b0;
    case (state)
      IDLE: begin
        beep_nxt = 1'b0;
        if (sel_vld) begin
          pending_nxt[sel_idx] = 1'b0;
          id_nxt    = sel_idx;
          ring_nxt  = RING_LD;
          snz_nxt   = '0;
          state_nxt = RINGING;
        end
      end
      RINGING: begin
        if (ack) begin
          state_nxt = IDLE;
          beep_nxt  = 1'b0;
        end else if (abort) begin
          state_nxt         = IDLE;
          beep_nxt          = 1'b0;
          pending_nxt[id_r] = 1'b0;
        end else if (snooze) begin
          beep_nxt = 1'b0;
          if (snz_cnt < SNZ_MAX) begin
            state_nxt = SNOOZE;
            snz_nxt   = snz_cnt + 4'd1;
            min_nxt   = SNOOZE_LD;
          end else begin
            state_nxt  = IDLE;
            missed_nxt = 1'b0;
          end
        end else if (sec_tick) begin
          if (ring_cnt == 8'd1) begin
            state_nxt  = IDLE;
            beep_nxt   = 1'b0;
            missed_nxt = 1'b1;
          end else begin
            ring_nxt = ring_cnt - 8'd1;
            beep_nxt = ~beep_r;
          end
        end
      end
      SNOOZE: begin
        beep_nxt = 1'b0;
        if (ack) begin
          state_nxt = IDLE;
        end else if (abort) begin
          state_nxt         = IDLE;
          pending_nxt[id_r] = 1'b0;
        end else if (min_tick) begin
          if (min_cnt == 4'd1) begin
            state_nxt = RINGING;
            ring_nxt  = RING_LD;
          end else begin
            min_nxt = min_cnt - 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      prev_match <= '0;
      slot_en    <= '0;
      id_r       <= '0;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
      min_cnt    <= '0;
      beep_r     <= 1'b0;
      missed_r   <= 1'b0;
      for (int i = 0; i < N_ALARMS; i++)
        slot_time[i] <= '0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      prev_match <= match;
      id_r       <= id_nxt;
      ring_cnt   <= ring_nxt;
      snz_cnt    <= snz_nxt;
      min_cnt    <= min_nxt;
      beep_r     <= beep_nxt;
      missed_r   <= missed_nxt;
      if (wr_en) begin
        slot_time[wr_idx] <= wr_time;
        slot_en[wr_idx]   <= wr_enable;
      end
    end
  end

  assign rd_time   = slot_time[rd_idx];
  assign rd_enable = slot_en[rd_idx];
  assign alarm     = (state == RINGING);
  assign snoozing  = (state == SNOOZE);
  assign beep      = beep_r;
  assign alarm_id  = id_r;
  assign missed    = missed_r;

endmodule
